// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared NPU constants (default pixel width, image size and
//               window size) and the window element bit-offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_IMG_W  = 28;
   localparam int DEF_IMG_H  = 28;
   localparam int DEF_K      = 3;

   // Bit offset of window element (r,c) in a flattened K*K window;
   // r=0 is the oldest line, c=0 the leftmost column.
   function automatic int win_offset(input int r, input int c,
                                     input int k, input int data_w);
      return (r * k + c) * data_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/line_delay.sv
`default_nettype none
// ============================================================================
// Module      : line_delay
// Description : Enabled shift register, DEPTH entries of WIDTH bits, with a
//               single output tap at the oldest entry. Used as one image
//               line of delay when DEPTH equals the image width.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               en   - shift enable (one entry per enabled cycle)
//               din  - value shifted in
//               dout - value shifted in DEPTH enabled cycles ago
// Revision    : 1.0 - initial release
// ============================================================================
module line_delay #(
   parameter int DEPTH = 28,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr_q [DEPTH];
   logic [WIDTH-1:0] sr_d [DEPTH];

   always_comb begin
      sr_d = sr_q;
      if (en) begin
         sr_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr_q[i] <= '0;
         end
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout = sr_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_buffer
// Description : Streaming KxK sliding-window generator. Accepts one raster-
//               order pixel per handshake, keeps K-1 previous lines in
//               delay lines and presents a full KxK window (registered,
//               valid/ready) for every valid output position.
// Ports       : clk, rst            - clock, async active-high reset
//               in_valid/in_data    - pixel input
//               in_ready            - pixel can be accepted this cycle
//               win_valid/win_ready - window output handshake
//               win_data            - KxK window, element (r,c) at
//                                     [(r*K+c)*DATA_W +: DATA_W]
//               win_row/win_col     - top-left coordinate of the window
//               frame_done          - pulse after last pixel of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_buffer
   import npu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int K      = DEF_K
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic [K*K*DATA_W-1:0]    win_data,
   output logic [$clog2(IMG_H)-1:0] win_row,
   output logic [$clog2(IMG_W)-1:0] win_col,
   output logic                     frame_done
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [DATA_W-1:0] win_q [K][K];
   logic [DATA_W-1:0] win_d [K][K];
   logic              win_valid_q, win_valid_d;
   logic [ROW_W-1:0]  win_row_q, win_row_d;
   logic [COL_W-1:0]  win_col_q, win_col_d;
   logic              frame_done_q, frame_done_d;

   logic [DATA_W-1:0] line_in  [K-1];
   logic [DATA_W-1:0] line_out [K-1];

   logic accept;
   logic last_col;
   logic last_row;
   logic emit;

   // Ready depends only on the output register state, never on in_valid.
   assign in_ready = !win_valid_q || win_ready;
   assign accept   = in_valid && in_ready;
   assign last_col = (col_q == COL_W'(IMG_W - 1));
   assign last_row = (row_q == ROW_W'(IMG_H - 1));
   assign emit     = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));

   // Chained line delays: line j output is the same column j+1 rows back.
   generate
      for (genvar j = 0; j < K - 1; j++) begin : g_line
         if (j == 0) begin : g_first
            assign line_in[j] = in_data;
         end else begin : g_chain
            assign line_in[j] = line_out[j-1];
         end

         line_delay #(
            .DEPTH (IMG_W),
            .WIDTH (DATA_W)
         ) u_line_delay (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (line_in[j]),
            .dout (line_out[j])
         );
      end
   endgenerate

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      win_valid_d  = win_valid_q;
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
      frame_done_d = 1'b0;

      if (accept) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end

         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
         end
         // New rightmost column: newest pixel at the bottom, oldest line on top.
         win_d[K-1][K-1] = in_data;
         for (int j = 0; j < K - 1; j++) begin
            win_d[K-2-j][K-1] = line_out[j];
         end

         frame_done_d = last_col && last_row;
      end

      if (accept && emit) begin
         win_valid_d = 1'b1;
         win_row_d   = row_q - ROW_W'(K - 1);
         win_col_d   = col_q - COL_W'(K - 1);
      end else if (win_ready) begin
         win_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   generate
      for (genvar r = 0; r < K; r++) begin : g_out_row
         for (genvar c = 0; c < K; c++) begin : g_out_col
            assign win_data[win_offset(r, c, K, DATA_W) +: DATA_W] = win_q[r][c];
         end
      end
   endgenerate

   assign win_valid  = win_valid_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire
